mem_bus_bridge: RTL and testbench

- Sits directly downstream of the load/store alignment stage.
- Consumes its word-addressed request (re, byte-lane we, 30-bit word address, lane-aligned write data).
- Runs that request as a valid/ready transaction on an external memory bus with variable latency, and stalls the pipeline until the bus responds.
- Returns registered read data so the alignment stage sees rdata_in on the cycle after it advances.

---
 rtl/mem_bus_bridge.sv | 152 +++++++++++++++
 tb/tb_mem_bus_bridge.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_bridge.sv
// mem_bus_bridge
//   Turns one word-addressed load/store request from the alignment stage into
//   a valid/ready transaction on an external memory bus with variable latency.
//   The pipeline is stalled until the bus responds, and read data is
//   registered so the alignment stage sees it in the cycle after it advances.
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   re, we, addr, wdata   request from the alignment stage (we != 0 => write)
//   rdata                 registered read data back to the alignment stage
//   stall                 holds the pipeline while a transaction is in flight
//   bus_err               one-cycle pulse when a response times out
//   bus_valid/bus_ready   request handshake; bus_addr/bus_we/bus_wdata fields
//   bus_rvalid/bus_rdata  response (acknowledges reads and writes)
//
// state  | meaning
// IDLE   | no transaction; a request is latched onto the bus the cycle it appears
// REQ    | bus_valid high, waiting for bus_ready
// RESP   | request accepted, waiting for bus_rvalid (timeout counter running)
// DONE   | pipeline released for one cycle; request inputs ignored
module mem_bus_bridge #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        re,
  input  logic [3:0]  we,
  input  logic [29:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        bus_err,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic [29:0] bus_addr,
  output logic [3:0]  bus_we,
  output logic [31:0] bus_wdata,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DONE} state_t;

  // Counter value on the last RESP cycle allowed before aborting.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [31:0] rdata_q, rdata_d;
  logic        valid_q, valid_d;
  logic [29:0] addr_q, addr_d;
  logic [3:0]  we_q, we_d;
  logic [31:0] wdata_q, wdata_d;
  logic        err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic req;
  logic is_read;
  logic timeout_hit;

  assign req         = re | (we != 4'b0000);
  assign is_read     = (we_q == 4'b0000);
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      rdata_q <= '0;
      valid_q <= 1'b0;
      addr_q  <= '0;
      we_q    <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and datapath updates
  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          valid_d = 1'b1;
          addr_d  = addr;
          we_d    = we;     // a read carries we == 0, so re needs no separate latch
          wdata_d = wdata;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (bus_ready) begin
          valid_d = 1'b0;
          cnt_d   = '0;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
        if (bus_rvalid) begin
          if (is_read) rdata_d = bus_rdata;
          state_d = S_DONE;
        end else if (timeout_hit) begin
          err_d = 1'b1;
          if (is_read) rdata_d = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs; stall in IDLE must rise in the same cycle the request appears.
  always_comb begin
    stall = 1'b0;
    if (!reset) begin
      unique case (state_q)
        S_IDLE:  stall = req;
        S_REQ:   stall = 1'b1;
        S_RESP:  stall = 1'b1;
        S_DONE:  stall = 1'b0;
        default: stall = 1'b0;
      endcase
    end
  end

  assign rdata     = rdata_q;
  assign bus_valid = valid_q;
  assign bus_addr  = addr_q;
  assign bus_we    = we_q;
  assign bus_wdata = wdata_q;
  assign bus_err   = err_q;

endmodule

// File: tb/tb_mem_bus_bridge.sv
module tb_mem_bus_bridge;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        re;
  logic [3:0]  we;
  logic [29:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        bus_err;
  logic        bus_valid;
  logic        bus_ready;
  logic [29:0] bus_addr;
  logic [3:0]  bus_we;
  logic [31:0] bus_wdata;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  int n_chk  = 0;
  int n_pass = 0;
  logic [31:0] mdl_rdata;

  mem_bus_bridge #(.TIMEOUT(TMO), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .re(re), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .stall(stall), .bus_err(bus_err), .bus_valid(bus_valid),
    .bus_ready(bus_ready), .bus_addr(bus_addr), .bus_we(bus_we),
    .bus_wdata(bus_wdata), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (!reset) assert (!(re && (we != 4'b0000)))
      else $error("FAIL illegal_req re=%0b we=%b", re, we);

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
  endtask

  // Idle cycles: no request, spurious bus_rvalid/bus_ready must do nothing.
  task automatic idle(input int n);
    re = 1'b0; we = 4'b0000;
    bus_ready = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'h1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #2;
      chk("idle_stall", 32'(stall), 32'd0);
      chk("idle_valid", 32'(bus_valid), 32'd0);
      chk("idle_rdata", rdata, mdl_rdata);
    end
    bus_ready = 1'b0; bus_rvalid = 1'b0;
  endtask

  // One transaction. dr = REQ cycles before bus_ready, dv = RESP cycles before
  // bus_rvalid (>= TMO means the response never arrives in time).
  // from_done: task entered during the previous DONE cycle (back-to-back).
  task automatic run_txn(input logic rd, input logic [3:0] wen, input logic [29:0] a,
                         input logic [31:0] wd, input logic [31:0] rsp,
                         input int dr, input int dv, input logic spur,
                         input int abort_at, input bit from_done);
    bit          is_wr     = (wen != 4'b0000);
    bit          exp_to    = (dv >= TMO);
    int          exp_stall = 1 + (dr + 1) + (exp_to ? TMO : dv + 1);
    logic [31:0] exp_rd    = is_wr ? mdl_rdata : (exp_to ? 32'h0 : rsp);
    int n_st = 0, n_val = 0, n_err = 0, vcnt = 0, rcnt = 0, n_cyc = 0;
    bit ph = 0, seen = 0, done = 0;
    re = rd; we = wen; addr = a; wdata = wd;
    bus_ready = 1'b0; bus_rvalid = spur; bus_rdata = 32'h1;
    #1;
    if (stall) begin n_st++; seen = 1; end
    for (int c = 0; c < 200 && !done; c++) begin
      @(posedge clk); #2;
      n_cyc++;
      if (bus_valid) begin
        n_val++;
        chk("bus_addr", 32'(bus_addr), 32'(a));
        chk("bus_we", 32'(bus_we), 32'(wen));
        chk("bus_wdata", bus_wdata, wd);
      end
      if (bus_err) n_err++;
      if (seen && !stall) begin
        done = 1;
        re = 1'b0; we = 4'b0000; bus_ready = 1'b0; bus_rvalid = 1'b0;
      end else begin
        if (stall) begin n_st++; seen = 1; end
        chk("rdata_hold", rdata, mdl_rdata);
        if (!ph) begin
          bus_ready = bus_valid && (vcnt == dr);
          if (bus_valid) vcnt++;
          bus_rvalid = spur; bus_rdata = 32'h1;
          if (bus_ready) ph = 1;
        end else begin
          if (rcnt == abort_at) begin
            reset = 1'b1;
            #1;
            chk("abort_stall", 32'(stall), 32'd0);
            chk("abort_valid", 32'(bus_valid), 32'd0);
            chk("abort_rdata", rdata, 32'd0);
            chk("abort_err", 32'(bus_err), 32'd0);
            re = 1'b0; we = 4'b0000; bus_ready = 1'b0; bus_rvalid = 1'b0;
            @(posedge clk); #1;
            reset = 1'b0;
            mdl_rdata = 32'h0;
            return;
          end
          bus_ready  = 1'b0;
          bus_rvalid = (rcnt == dv);
          bus_rdata  = bus_rvalid ? rsp : (32'hDEAD0000 ^ 32'(rcnt));
          rcnt++;
        end
      end
    end
    chk("txn_completed", 32'(done), 32'd1);
    chk("stall_cycles", 32'(n_st), 32'(exp_stall));
    chk("valid_cycles", 32'(n_val), 32'(dr + 1));
    chk("err_pulses", 32'(n_err), 32'(exp_to));
    chk("txn_cycles", 32'(n_cyc), 32'(exp_stall + (from_done ? 1 : 0)));
    chk("rdata_done", rdata, exp_rd);
    mdl_rdata = exp_rd;
  endtask

  initial begin
    reset = 1'b1; re = 1'b0; we = 4'b0000; addr = '0; wdata = '0;
    bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
    mdl_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_valid", 32'(bus_valid), 32'd0);
    chk("rst_addr", 32'(bus_addr), 32'd0);
    chk("rst_we", 32'(bus_we), 32'd0);
    chk("rst_wdata", bus_wdata, 32'h0);
    chk("rst_err", 32'(bus_err), 32'd0);
    reset = 1'b0;
    idle(2);

    // read, zero wait
    run_txn(1'b1, 4'b0000, 30'h10, 32'h0, 32'hCAFEF00D, 0, 0, 1'b0, -1, 1'b0);
    idle(1);
    // byte write, bus_ready delayed 3 cycles
    run_txn(1'b0, 4'b0100, 30'h20, 32'h00AB0000, 32'h0, 3, 1, 1'b0, -1, 1'b0);
    idle(1);
    // back-to-back read then write
    run_txn(1'b1, 4'b0000, 30'h30, 32'h0, 32'h12345678, 1, 0, 1'b0, -1, 1'b0);
    run_txn(1'b0, 4'b1111, 30'h31, 32'hA5A5A5A5, 32'h0, 0, 2, 1'b0, -1, 1'b1);
    idle(1);
    // timeout: bus_rvalid never arrives
    run_txn(1'b1, 4'b0000, 30'h40, 32'h0, 32'h55AA55AA, 0, 1000, 1'b0, -1, 1'b0);
    idle(2);
    // spurious responses in IDLE and REQ
    run_txn(1'b1, 4'b0000, 30'h50, 32'h0, 32'h0BADBEEF, 2, 1, 1'b1, -1, 1'b0);
    idle(2);
    // reset while in RESP, then a normal read
    run_txn(1'b1, 4'b0000, 30'h60, 32'h0, 32'h77777777, 0, 10, 1'b0, 2, 1'b0);
    idle(1);
    run_txn(1'b1, 4'b0000, 30'h61, 32'h0, 32'h13579BDF, 1, 1, 1'b0, -1, 1'b0);

    // randomized traffic
    for (int i = 0; i < 24; i++) begin
      bit          wr  = 1'($urandom_range(0, 1));
      logic [3:0]  wen = wr ? 4'($urandom_range(1, 15)) : 4'b0000;
      int          gap = $urandom_range(0, 2);
      if (gap > 0) idle(gap);
      run_txn(!wr, wen, 30'($urandom), $urandom, $urandom,
              $urandom_range(0, 3), $urandom_range(0, 5), 1'($urandom_range(0, 1)),
              -1, (gap == 0));
    end
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
